// File: rtl/demux_pkg.sv
// Shared definitions for the demux frame collector: channel count, FSM encoding
// and the mask popcount helper.
package demux_pkg;

  localparam int NCH = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  function automatic logic [3:0] popcount8(input logic [NCH-1:0] m);
    logic [3:0] cnt;
    cnt = '0;
    for (int i = 0; i < NCH; i++) cnt = cnt + 4'(m[i]);
    return cnt;
  endfunction

endpackage

// File: rtl/demux_frame_collector_demux.sv
// 1-to-8 demultiplexer: routes din to the output selected by sel, others low.
module demux_1to8 (
  input  logic       din,
  input  logic [2:0] sel,
  output logic [7:0] dout
);

  always_comb begin
    dout      = '0;
    dout[sel] = din;
  end

endmodule

// File: rtl/demux_frame_collector.sv
// Collects single-bit channel writes into an 8-bit frame and hands the complete
// frame to a consumer with a valid/ready handshake.
module demux_frame_collector
  import demux_pkg::*;
#(
  parameter int NCH = demux_pkg::NCH
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           y,
  input  logic [2:0]     sel,
  input  logic           flush,
  output logic [NCH-1:0] frame_out,
  output logic           frame_valid,
  input  logic           frame_ready,
  output logic [3:0]     fill_count,
  output logic           dup_err
);

  state_t         state, state_nxt;
  logic           accept;
  logic [NCH-1:0] we;
  logic [NCH-1:0] mask, mask_nxt;
  logic [NCH-1:0] frame_nxt;

  assign in_ready    = (state == COLLECT);
  assign frame_valid = (state == HOLD);
  assign accept      = in_valid & in_ready & ~flush;

  demux_1to8 u_we_demux (
    .din  (accept),
    .sel  (sel),
    .dout (we)
  );

  always_comb begin
    state_nxt = state;
    mask_nxt  = mask;
    frame_nxt = frame_out;
    case (state)
      COLLECT: begin
        if (flush) begin
          mask_nxt = '0;
        end else if (accept) begin
          mask_nxt  = mask | we;
          // Enable-gated data keeps writes of 0 and 1 symmetric.
          frame_nxt = (frame_out & ~we) | ({NCH{y}} & we);
          if (&mask_nxt) state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (frame_ready) begin
          mask_nxt  = '0;
          state_nxt = COLLECT;
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= COLLECT;
      mask       <= '0;
      frame_out  <= '0;
      fill_count <= '0;
      dup_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      mask       <= mask_nxt;
      frame_out  <= frame_nxt;
      fill_count <= popcount8(mask_nxt);
      dup_err    <= |(we & mask);
    end
  end

endmodule

// File: tb/tb_demux_frame_collector.sv
// Directed, table-driven bench for demux_frame_collector with a few hand-written
// multi-cycle sequences.
module tb_demux_frame_collector;

  logic       clk = 1'b0;
  logic       rst, in_valid, y, flush, frame_ready;
  logic [2:0] sel;
  logic       in_ready, frame_valid, dup_err;
  logic [7:0] frame_out;
  logic [3:0] fill_count;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst, iv, y, fl, fr;
    logic [2:0] sel;
    logic       e_ir, e_fv, e_de;
    logic [7:0] e_fo;
    logic [3:0] e_fc;
    string      tag;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  demux_frame_collector #(.NCH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .y           (y),
    .sel         (sel),
    .flush       (flush),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .fill_count  (fill_count),
    .dup_err     (dup_err)
  );

  task automatic add(input string tag, input logic r, input logic iv, input logic [2:0] s,
                     input logic yy, input logic fl, input logic fr, input logic ir,
                     input logic fv, input logic [7:0] fo, input logic [3:0] fc,
                     input logic de);
    vec_t v;
    v.tag = tag; v.rst = r; v.iv = iv; v.sel = s; v.y = yy; v.fl = fl; v.fr = fr;
    v.e_ir = ir; v.e_fv = fv; v.e_fo = fo; v.e_fc = fc; v.e_de = de;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input logic [2:0] s, input logic yy,
                       input logic fl, input logic fr);
    rst = r; in_valid = iv; sel = s; y = yy; flush = fl; frame_ready = fr;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic ir, input logic fv,
                           input logic [7:0] fo, input logic [3:0] fc, input logic de);
    chk({tag, ".in_ready"},    {7'd0, in_ready},    {7'd0, ir});
    chk({tag, ".frame_valid"}, {7'd0, frame_valid}, {7'd0, fv});
    chk({tag, ".frame_out"},   frame_out,           fo);
    chk({tag, ".fill_count"},  {4'd0, fill_count},  {4'd0, fc});
    chk({tag, ".dup_err"},     {7'd0, dup_err},     {7'd0, de});
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; sel = '0; y = 1'b0; flush = 1'b0; frame_ready = 1'b0;

    //   tag       rst iv sel y  fl fr   ir fv fo     fc  de
    add("reset",   1, 0, 0, 0, 0, 0,   1, 0, 8'h00, 0, 0);
    // Frame 1: y = 1,0,1,1,0,0,1,0 -> 8'h4D; frame_ready high on the 8th write
    add("w0",      0, 1, 0, 1, 0, 0,   1, 0, 8'h01, 1, 0);
    add("w1",      0, 1, 1, 0, 0, 0,   1, 0, 8'h01, 2, 0);
    add("w2",      0, 1, 2, 1, 0, 0,   1, 0, 8'h05, 3, 0);
    add("w3",      0, 1, 3, 1, 0, 0,   1, 0, 8'h0D, 4, 0);
    add("w4",      0, 1, 4, 0, 0, 0,   1, 0, 8'h0D, 5, 0);
    add("w5",      0, 1, 5, 0, 0, 0,   1, 0, 8'h0D, 6, 0);
    add("w6",      0, 1, 6, 1, 0, 0,   1, 0, 8'h4D, 7, 0);
    add("w7",      0, 1, 7, 0, 0, 1,   0, 1, 8'h4D, 8, 0);
    // HOLD: ignore writes and flush while frame_ready is low
    for (int i = 0; i < 5; i++)
      add("hold",  0, 1, 0, 1, 1, 0,   0, 1, 8'h4D, 8, 0);
    // Handshake cycle: write offered but not taken
    add("hs",      0, 1, 0, 0, 0, 1,   1, 0, 8'h4D, 0, 0);
    // Duplicate write to channel 3
    add("dup_a",   0, 1, 3, 1, 0, 0,   1, 0, 8'h4D, 1, 0);
    add("dup_b",   0, 1, 3, 0, 0, 0,   1, 0, 8'h45, 1, 1);
    add("idle",    0, 0, 5, 1, 0, 1,   1, 0, 8'h45, 1, 0);
    add("flush0",  0, 0, 0, 0, 1, 0,   1, 0, 8'h45, 0, 0);
    // Five writes, then flush with a write offered to channel 6
    add("f_w0",    0, 1, 0, 1, 0, 0,   1, 0, 8'h45, 1, 0);
    add("f_w1",    0, 1, 1, 1, 0, 0,   1, 0, 8'h47, 2, 0);
    add("f_w2",    0, 1, 2, 1, 0, 0,   1, 0, 8'h47, 3, 0);
    add("f_w3",    0, 1, 3, 1, 0, 0,   1, 0, 8'h4F, 4, 0);
    add("f_w4",    0, 1, 4, 1, 0, 0,   1, 0, 8'h5F, 5, 0);
    add("flush1",  0, 1, 6, 0, 1, 0,   1, 0, 8'h5F, 0, 0);
    // Eight fresh writes required after the flush
    add("g_w0",    0, 1, 0, 0, 0, 0,   1, 0, 8'h5E, 1, 0);
    add("g_w1",    0, 1, 1, 0, 0, 0,   1, 0, 8'h5C, 2, 0);
    add("g_w2",    0, 1, 2, 0, 0, 0,   1, 0, 8'h58, 3, 0);
    add("g_w3",    0, 1, 3, 0, 0, 0,   1, 0, 8'h50, 4, 0);
    add("g_w4",    0, 1, 4, 0, 0, 0,   1, 0, 8'h40, 5, 0);
    add("g_w5",    0, 1, 5, 0, 0, 0,   1, 0, 8'h40, 6, 0);
    add("g_w6",    0, 1, 6, 0, 0, 0,   1, 0, 8'h00, 7, 0);
    add("g_w7",    0, 1, 7, 1, 0, 0,   0, 1, 8'h80, 8, 0);
    add("g_hs",    0, 0, 0, 0, 0, 1,   1, 0, 8'h80, 0, 0);
    // Six writes then reset with a write offered
    add("r_w0",    0, 1, 0, 1, 0, 0,   1, 0, 8'h81, 1, 0);
    add("r_w1",    0, 1, 1, 1, 0, 0,   1, 0, 8'h83, 2, 0);
    add("r_w2",    0, 1, 2, 1, 0, 0,   1, 0, 8'h87, 3, 0);
    add("r_w3",    0, 1, 3, 1, 0, 0,   1, 0, 8'h8F, 4, 0);
    add("r_w4",    0, 1, 4, 1, 0, 0,   1, 0, 8'h9F, 5, 0);
    add("r_w5",    0, 1, 5, 1, 0, 0,   1, 0, 8'hBF, 6, 0);
    add("r_rst",   1, 1, 6, 1, 0, 0,   1, 0, 8'h00, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].sel, tbl[i].y, tbl[i].fl, tbl[i].fr);
      check_all($sformatf("%s[%0d]", tbl[i].tag, i), tbl[i].e_ir, tbl[i].e_fv,
                tbl[i].e_fo, tbl[i].e_fc, tbl[i].e_de);
    end

    // Hand sequence: fill a frame with alternating bits, then reset during a
    // HOLD handshake; reset must win.
    for (int k = 0; k < 8; k++) begin
      drive(1'b0, 1'b1, 3'(k), k[0], 1'b0, 1'b0);
      chk($sformatf("alt_fill[%0d]", k), {4'd0, fill_count}, 8'(k + 1));
    end
    check_all("alt_hold", 1'b0, 1'b1, 8'hAA, 4'd8, 1'b0);
    drive(1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 1'b1);
    check_all("rst_in_hold", 1'b1, 1'b0, 8'h00, 4'd0, 1'b0);

    // Hand sequence: dup_err lasts exactly one cycle even with back-to-back
    // duplicates followed by a fresh channel.
    drive(1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0);
    check_all("dup2_a", 1'b1, 1'b0, 8'h80, 4'd1, 1'b1);
    drive(1'b0, 1'b1, 3'd1, 1'b1, 1'b0, 1'b0);
    check_all("dup2_b", 1'b1, 1'b0, 8'h82, 4'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux_frame_collector.md
DEMUX_FRAME_COLLECTOR -- requirements
Module: demux_frame_collector

Interface
REQ-001 SHALL have parameter NCH, default 8, meaning the channel count; fixed at 8, with no other value supported.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 SHALL have port in_valid  input  1  a channel write is offered.
REQ-005 SHALL have port in_ready  output  1  the block accepts a write this cycle.
REQ-006 SHALL have port y  input  1  the data bit for the addressed channel.
REQ-007 SHALL have port sel  input  3  the channel index, 0..7.
REQ-008 SHALL have port flush  input  1  discards the partial frame.
REQ-009 SHALL have port frame_out  output  8  the assembled frame; bit k holds channel k.
REQ-010 SHALL have port frame_valid  output  1  frame_out is complete and stable.
REQ-011 SHALL have port frame_ready  input  1  the consumer takes the frame.
REQ-012 SHALL have port fill_count  output  4  the number of distinct channels written, 0..8.
REQ-013 SHALL have port dup_err  output  1  one-cycle pulse when an accepted write targets an already-written channel.

Function
REQ-014 SHALL implement the two states COLLECT and HOLD.
REQ-015 SHALL drive in_ready = 1 only in COLLECT; frame_valid = 1 only in HOLD.
REQ-016 SHALL accept a write when in_valid && in_ready (with flush = 0) and on that edge: frame_out[sel] <= y, mask[sel] <= 1, all other bits unchanged.
REQ-017 SHALL derive the per-channel write enable as the one-hot decode of sel gated by accept, with y as the data value, so that writes of 0 and of 1 both land.
REQ-018 SHALL, on an accepted write where mask[sel] was already 1: overwrite the bit, leave mask and fill_count unchanged, and pulse dup_err high for the next cycle only.
REQ-019 SHALL set fill_count to the popcount of mask, registered and updated on the same edge as mask.
REQ-020 SHALL transition COLLECT->HOLD on the edge where the accepted write makes mask all ones; frame_valid is high the following cycle, giving one cycle of latency from the 8th write.
REQ-021 SHALL hold frame_out and frame_valid stable in HOLD until frame_valid && frame_ready.
REQ-022 SHALL, on the HOLD handshake edge: clear mask and fill_count to 0, return to COLLECT, and leave frame_out holding its last value.
REQ-023 SHALL keep in_ready = 0 in the handshake cycle itself, with no same-cycle bypass; the first new write is accepted one cycle later.
REQ-024 SHALL, when flush = 1 in COLLECT: clear mask and fill_count and accept no write that cycle, even if in_valid = 1.
REQ-025 SHALL ignore flush in HOLD; only the frame_ready handshake leaves HOLD.
REQ-026 SHALL leave all state unchanged for in_valid = 0 or when in HOLD, apart from REQ-022.
REQ-027 SHALL treat frame_ready as don't-care in COLLECT.

Reset
REQ-028 SHALL, on rst = 1 at a rising edge: state = COLLECT, mask = 0, frame_out = 8'h00, fill_count = 0, dup_err = 0, frame_valid = 0, in_ready = 1 from the next cycle.
REQ-029 SHALL give rst priority over every other input, including a mid-frame write and a HOLD handshake.

Structure
REQ-030 SHALL place the state encoding (COLLECT = 0, HOLD = 1) and NCH in a shared package, demux_pkg.
REQ-031 SHALL generate the one-hot write-enable with one instance of the existing 1-to-8 demultiplexer (input tied to accept, select = sel); no other sub-modules.
REQ-032 SHALL register all outputs except in_ready and frame_valid, which decode directly from the state register.

Verification
REQ-033 SHALL cover: reset, then writes sel = 0..7 with y = 1,0,1,1,0,0,1,0 -> frame_valid is high the cycle after the 8th write, frame_out = 8'h4D, fill_count = 8.
REQ-034 SHALL cover: in HOLD, frame_ready low for 5 cycles, then high -> frame_out stable at 8'h4D throughout, in_ready = 0, and COLLECT with fill_count = 0 after the handshake.
REQ-035 SHALL cover: writes sel = 3 (y = 1), then sel = 3 (y = 0) -> dup_err pulses for one cycle, fill_count = 1, frame_out[3] = 0.
REQ-036 SHALL cover: 5 writes, then flush with in_valid = 1 and sel = 6 -> fill_count = 0, frame_out[6] unchanged, and 8 further writes are needed to complete the frame.
REQ-037 SHALL cover: rst asserted after 6 writes -> next cycle fill_count = 0, frame_out = 8'h00, in_ready = 1, frame_valid = 0.
REQ-038 SHALL cover: 8th write and frame_ready = 1 in the same cycle -> frame_valid rises next cycle, and the frame is released only on a later cycle with frame_ready high.
